// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master RAM port arbiter.
package mem_arb_pkg;
  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready master bus and synchronous RAM port bundles.
interface mem_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

interface ram_if #(
  parameter int AW     = 14,
  parameter int DATA_W = 32
);
  logic                en;
  logic [DATA_W/8-1:0] we;
  logic [AW-1:0]       addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way picker: on a tie, the master not granted last wins
// unless fixed priority hands every tie to M0.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (fixed_prio || last_grant == M1) ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous RAM port between two valid/ready masters, one access
// at a time (IDLE -> ISSUE -> RESP), with range checking and a sticky error.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MEM_DEPTH  = 16384,
  parameter logic [ADDR_W-1:0] MEM_BASE   = '0,
  parameter bit                FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  mem_req_if.slave   m0,
  mem_req_if.slave   m1,
  ram_if.master      ram,
  output logic [1:0] grant,
  output logic       bus_err,
  input  logic       err_clr
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int NB = DATA_W / 8;
  // One extra bit so the window end never wraps.
  localparam logic [ADDR_W:0] LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(64'(MEM_DEPTH) << 2);

  arb_state_t        state_q, state_d;
  master_id_t        last_q, last_d;
  logic [1:0]        grant_q, grant_d, ready_q, ready_d, rsel_q, rsel_d;
  logic [1:0]        req, gnt;
  logic              en_q, en_d, rng_q, rng_d, rd_q, rd_d, err_q, err_d;
  logic [NB-1:0]     we_q, we_d, sel_wstrb;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_wdata;
  logic [ADDR_W-1:0] sel_addr, off;
  logic              sel_ok;

  assign req = {m1.valid, m0.valid};

  rr_arb2 u_pick (
    .req       (req),
    .last_grant(last_q),
    .fixed_prio(FIXED_PRIO),
    .gnt       (gnt)
  );

  assign sel_addr  = gnt[1] ? m1.addr  : m0.addr;
  assign sel_wdata = gnt[1] ? m1.wdata : m0.wdata;
  assign sel_wstrb = gnt[1] ? m1.wstrb : m0.wstrb;
  assign sel_ok    = ({1'b0, sel_addr} >= LO) && ({1'b0, sel_addr} < HI);
  assign off       = sel_addr - MEM_BASE;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    rng_d   = rng_q;
    rd_d    = rd_q;
    en_d    = 1'b0;
    we_d    = '0;
    addr_d  = '0;
    wdata_d = '0;
    ready_d = '0;
    rsel_d  = '0;
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      IDLE: if (|req) begin
        grant_d = gnt;
        rng_d   = sel_ok;
        rd_d    = (sel_wstrb == '0);
        en_d    = sel_ok;
        if (sel_ok) begin
          we_d    = sel_wstrb;
          addr_d  = AW'(off >> 2);
          wdata_d = sel_wdata;
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        ready_d = grant_q;
        rsel_d  = (rng_q && rd_q) ? grant_q : 2'b00;
        if (!rng_q) err_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        last_d  = grant_q[1] ? M1 : M0;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= M1;
      grant_q <= '0;
      rng_q   <= 1'b0;
      rd_q    <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      rsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rng_q   <= rng_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rsel_q  <= rsel_d;
      err_q   <= err_d;
    end
  end

  assign ram.en    = en_q;
  assign ram.we    = we_q;
  assign ram.addr  = addr_q;
  assign ram.wdata = wdata_q;
  assign grant     = grant_q;
  assign bus_err   = err_q;

  // RAM data is already a register output; a registered select steers it.
  assign m0.ready = ready_q[0];
  assign m1.ready = ready_q[1];
  assign m0.rdata = rsel_q[0] ? ram.rdata : '0;
  assign m1.rdata = rsel_q[1] ? ram.rdata : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int DEPTH = 16384;
  localparam int AW    = 14;

  logic       clk = 1'b0, rst = 1'b1, err_clr = 1'b0, f_err_clr = 1'b0;
  logic [1:0] grant, fgrant;
  logic       bus_err, fbus_err;

  always #5 clk = ~clk;

  mem_req_if #(32, 32) m0 (), m1 (), f0 (), f1 ();
  ram_if #(AW, 32) rb (), fb ();

  mem_bus_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .ram(rb),
    .grant(grant), .bus_err(bus_err), .err_clr(err_clr));

  mem_bus_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .m0(f0), .m1(f1), .ram(fb),
    .grant(fgrant), .bus_err(fbus_err), .err_clr(f_err_clr));

  assign fb.rdata = 32'h0000_1111;

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A5_0000;
  endfunction

  // Synchronous RAM; contents reload on reset.
  logic [31:0] mem [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rb.rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (rb.en) begin
      rb.rdata <= mem[rb.addr];
      for (int b = 0; b < 4; b++)
        if (rb.we[b]) mem[rb.addr][8*b +: 8] <= rb.wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic [1:0]  grant;
    logic        en;
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [1:0]  ready;
    logic [31:0] rd0, rd1;
  } exp_t;

  typedef struct {
    int          m;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        x_en;
    logic [13:0] x_addr;
    logic [31:0] x_rd;
    logic        x_err;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  logic [31:0] gold [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t zexp();
    exp_t e;
    e = '{grant: 2'b0, en: 1'b0, we: 4'b0, addr: 14'b0, wdata: 32'b0,
          ready: 2'b0, rd0: 32'b0, rd1: 32'b0};
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".grant"}, 64'(grant), 64'(e.grant));
    chk({tag, ".ram"}, 64'({rb.en, rb.we, rb.addr, rb.wdata}),
        64'({e.en, e.we, e.addr, e.wdata}));
    chk({tag, ".ready"}, 64'({m1.ready, m0.ready}), 64'(e.ready));
    chk({tag, ".rd0"}, 64'(m0.rdata), 64'(e.rd0));
    chk({tag, ".rd1"}, 64'(m1.rdata), 64'(e.rd1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (m == 0) begin m0.valid = v; m0.addr = a; m0.wstrb = s; m0.wdata = d; end
    else        begin m1.valid = v; m1.addr = a; m1.wstrb = s; m1.wdata = d; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    err_clr = 1'b0;
    gold.delete();
    tick();
    check_all("reset", zexp());
    chk("reset.err", 64'(bus_err), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gword(int i);
    return gold.exists(i) ? gold[i] : init_word(i);
  endfunction

  // Transaction-level effect of one access: what the RAM port shows while it
  // is issued and what the winner sees on completion.
  task automatic model_access(input int w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output exp_t iss, output exp_t rsp,
                              output bit oor);
    int idx;
    logic [31:0] word, rd;
    iss = zexp();
    rsp = zexp();
    rd  = '0;
    oor = !(64'(a) < 64'(4 * DEPTH));
    iss.grant = 2'(1 << w);
    rsp.grant = iss.grant;
    rsp.ready = iss.grant;
    if (!oor) begin
      idx = int'(a >> 2);
      iss.en = 1'b1; iss.we = s; iss.addr = 14'(idx); iss.wdata = d;
      word = gword(idx);
      if (s == 4'b0) rd = word;
      else begin
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        gold[idx] = word;
      end
    end
    if (w == 0) rsp.rd0 = rd; else rsp.rd1 = rd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0001_0000 + ($urandom & 32'h0000_FFF0);
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endcase
  endfunction

  vec_t vecs [8];
  exp_t e, iss, rsp;
  exp_t ring [4];
  bit   oor;
  int   cnt0, cnt1;

  initial begin
    logic [31:0] rd2;
    logic        v [2];
    int          last_m, free_at, err_at;

    f0.valid = 1'b0; f0.addr = '0; f0.wstrb = '0; f0.wdata = '0;
    f1.valid = 1'b0; f1.addr = '0; f1.wstrb = '0; f1.wdata = '0;

    rd2 = (init_word(2) & 32'hFFFF_00FF) | 32'h0000_AB00;
    vecs[0] = '{0, 32'h0000_0040, 4'h0, 32'h0,          1'b1, 14'h0010, 32'hDEADBEEF,     1'b0};
    vecs[1] = '{1, 32'h0000_0008, 4'h2, 32'h0000_AB00,  1'b1, 14'h0002, 32'h0,            1'b0};
    vecs[2] = '{1, 32'h0000_0008, 4'h0, 32'h0,          1'b1, 14'h0002, rd2,              1'b0};
    vecs[3] = '{0, 32'h0000_0043, 4'h0, 32'h0,          1'b1, 14'h0010, 32'hDEADBEEF,     1'b0};
    vecs[4] = '{0, 32'h0000_FFFC, 4'h0, 32'h0,          1'b1, 14'h3FFF, init_word(16383), 1'b0};
    vecs[5] = '{0, 32'h0001_0000, 4'h0, 32'h0,          1'b0, 14'h0,    32'h0,            1'b1};
    vecs[6] = '{1, 32'hFFFF_FFFC, 4'hF, 32'h1234_5678,  1'b0, 14'h0,    32'h0,            1'b1};
    vecs[7] = '{1, 32'h0000_0004, 4'h9, 32'hAABB_CCDD,  1'b1, 14'h0001, 32'h0,            1'b1};

    // Directed single-master accesses.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].m, 1'b1, vecs[k].a, vecs[k].s, vecs[k].d);
      tick();
      e = zexp();
      e.grant = 2'(1 << vecs[k].m);
      e.en    = vecs[k].x_en;
      e.addr  = vecs[k].x_addr;
      e.we    = vecs[k].x_en ? vecs[k].s : 4'h0;
      e.wdata = vecs[k].x_en ? vecs[k].d : 32'h0;
      check_all($sformatf("v%0d.iss", k), e);
      tick();
      e = zexp();
      e.grant = 2'(1 << vecs[k].m);
      e.ready = e.grant;
      if (vecs[k].m == 0) e.rd0 = vecs[k].x_rd; else e.rd1 = vecs[k].x_rd;
      check_all($sformatf("v%0d.rsp", k), e);
      chk($sformatf("v%0d.err", k), 64'(bus_err), 64'(vecs[k].x_err));
      drive(vecs[k].m, 1'b0, '0, '0, '0);
      tick();
      check_all($sformatf("v%0d.idle", k), zexp());
    end

    // Clear, then clear held across a new out-of-range access: set wins.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err.clr", 64'(bus_err), 64'd0);
    err_clr = 1'b1;
    drive(0, 1'b1, 32'h0001_0000, 4'h0, 32'h0);
    tick();
    tick();
    chk("err.setwins", 64'(bus_err), 64'd1);
    drive(0, 1'b0, '0, '0, '0);
    tick();
    chk("err.clrheld", 64'(bus_err), 64'd0);
    err_clr = 1'b0;

    // Both valid in the first cycle after reset: M0 first, then M1.
    do_reset();
    drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h44, 4'h0, 32'h0);
    tick();
    chk("tie.g0", 64'(grant), 64'b01);
    tick();
    chk("tie.r0", 64'({m1.ready, m0.ready}), 64'b01);
    chk("tie.d0", 64'(m0.rdata), 64'hDEADBEEF);
    drive(0, 1'b0, '0, '0, '0);
    tick();
    chk("tie.idle", 64'({grant, m1.ready, m0.ready}), 64'd0);
    tick();
    chk("tie.g1", 64'(grant), 64'b10);
    tick();
    chk("tie.r1", 64'({m1.ready, m0.ready}), 64'b10);
    chk("tie.d1", 64'(m1.rdata), 64'(init_word(17)));
    drive(1, 1'b0, '0, '0, '0);

    // Continuous contention alternates.
    do_reset();
    drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h44, 4'h0, 32'h0);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("alt.g%0d", k), 64'(grant), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (grant == 2'b01) cnt0++;
      if (grant == 2'b10) cnt1++;
      tick();
      tick();
    end
    chk("alt.cnt0", 64'(cnt0), 64'd4);
    chk("alt.cnt1", 64'(cnt1), 64'd4);
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);

    // Reset during ISSUE aborts; the held request is served afterwards.
    do_reset();
    drive(0, 1'b1, 32'h40, 4'h0, 32'h0);
    tick();
    chk("rst.iss", 64'({grant, rb.en, rb.addr}), 64'({2'b01, 1'b1, 14'h10}));
    #1 rst = 1'b1;
    #1 check_all("rst.async", zexp());
    chk("rst.err", 64'(bus_err), 64'd0);
    tick();
    chk("rst.noready", 64'({m1.ready, m0.ready}), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst.reiss", 64'({grant, rb.en, rb.addr}), 64'({2'b01, 1'b1, 14'h10}));
    tick();
    chk("rst.reready", 64'({m1.ready, m0.ready}), 64'b01);
    chk("rst.rdata", 64'(m0.rdata), 64'hDEADBEEF);
    drive(0, 1'b0, '0, '0, '0);
    tick();

    // Fixed priority: M0 keeps winning until it drops valid.
    f0.valid = 1'b1; f0.addr = 32'h40;
    f1.valid = 1'b1; f1.addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fp.g%0d", k), 64'(fgrant), 64'b01);
      tick();
      chk($sformatf("fp.r%0d", k), 64'({f1.ready, f0.ready}), 64'b01);
      if (k == 3) f0.valid = 1'b0;
      tick();
    end
    tick();
    chk("fp.g1", 64'(fgrant), 64'b10);
    tick();
    chk("fp.r1", 64'({f1.ready, f0.ready}), 64'b10);
    chk("fp.d1", 64'(f1.rdata), 64'h0000_1111);
    f1.valid = 1'b0;

    // Randomized traffic against the transaction model.
    do_reset();
    for (int i = 0; i < 4; i++) ring[i] = zexp();
    v[0] = 1'b0; v[1] = 1'b0;
    last_m = 1; free_at = 0; err_at = 1 << 30;
    for (int c = 0; c < 800; c++) begin
      e = ring[c % 4];
      ring[c % 4] = zexp();
      check_all($sformatf("rnd%0d", c), e);
      chk($sformatf("rnd%0d.err", c), 64'(bus_err), 64'(c >= err_at));
      for (int m = 0; m < 2; m++) begin
        if (v[m] && e.ready[m]) v[m] = ($urandom_range(0, 2) == 0);
        else if (!v[m]) v[m] = ($urandom_range(0, 3) == 0);
        else continue;
        if (v[m])
          drive(m, 1'b1, rand_addr(), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                $urandom);
        else
          drive(m, 1'b0, '0, '0, '0);
      end
      if (c >= free_at && (v[0] || v[1])) begin
        int w;
        if (v[0] && v[1]) w = (last_m == 1) ? 0 : 1;
        else w = v[1] ? 1 : 0;
        last_m = w;
        if (w == 0) model_access(0, m0.addr, m0.wstrb, m0.wdata, iss, rsp, oor);
        else        model_access(1, m1.addr, m1.wstrb, m1.wdata, iss, rsp, oor);
        ring[(c + 1) % 4] = iss;
        ring[(c + 2) % 4] = rsp;
        if (oor && err_at > c + 2) err_at = c + 2;
        free_at = c + 3;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
